// File: rtl/regfile_port_arbiter_if.sv
// Bus bundle between the two requesters, the port arbiter and the 64x32 RegisterMemory port.
// Signal suffixes (_i/_o) are from the arbiter's point of view.
interface regfile_port_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              req0_i;
   logic              we0_i;
   logic [ADDR_W-1:0] rs0_i;
   logic [ADDR_W-1:0] rt0_i;
   logic [ADDR_W-1:0] rd0_i;
   logic [DATA_W-1:0] wdata0_i;

   logic              req1_i;
   logic              we1_i;
   logic [ADDR_W-1:0] rs1_i;
   logic [ADDR_W-1:0] rt1_i;
   logic [ADDR_W-1:0] rd1_i;
   logic [DATA_W-1:0] wdata1_i;

   logic              gnt0_o;
   logic              gnt1_o;
   logic              rvalid0_o;
   logic              rvalid1_o;
   logic [DATA_W-1:0] rs_data_o;
   logic [DATA_W-1:0] rt_data_o;

   logic [ADDR_W-1:0] rf_rs_o;
   logic [ADDR_W-1:0] rf_rt_o;
   logic [ADDR_W-1:0] rf_rd_o;
   logic [DATA_W-1:0] rf_data_in_o;
   logic              rf_write_o;
   logic [DATA_W-1:0] rf_rs_out_i;
   logic [DATA_W-1:0] rf_rt_out_i;

   modport slave (
      input  req0_i, we0_i, rs0_i, rt0_i, rd0_i, wdata0_i,
      input  req1_i, we1_i, rs1_i, rt1_i, rd1_i, wdata1_i,
      output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rs_data_o, rt_data_o,
      output rf_rs_o, rf_rt_o, rf_rd_o, rf_data_in_o, rf_write_o,
      input  rf_rs_out_i, rf_rt_out_i
   );

   modport master (
      output req0_i, we0_i, rs0_i, rt0_i, rd0_i, wdata0_i,
      output req1_i, we1_i, rs1_i, rt1_i, rd1_i, wdata1_i,
      input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rs_data_o, rt_data_o,
      input  rf_rs_o, rf_rt_o, rf_rd_o, rf_data_in_o, rf_write_o,
      output rf_rs_out_i, rf_rt_out_i
   );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter for the single RegisterMemory port: issue reg -> memory sample -> response capture.
// Define RF_ARB_FIXED_PRI_EN for fixed priority (req0 always wins); default is round-robin.
module regfile_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input logic                  clk,
   input logic                  rst,
   regfile_port_arbiter_if.slave bus
);

   logic              any_req;
   logic              win;
   logic              gnt0;
   logic              gnt1;
   logic              granted;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_rs;
   logic [ADDR_W-1:0] sel_rt;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_wdata;

   logic [ADDR_W-1:0] rf_rs_q,      rf_rs_d;
   logic [ADDR_W-1:0] rf_rt_q,      rf_rt_d;
   logic [ADDR_W-1:0] rf_rd_q,      rf_rd_d;
   logic [DATA_W-1:0] rf_data_in_q, rf_data_in_d;
   logic              rf_write_q,   rf_write_d;
   logic              v1_q,         v1_d;
   logic              tag1_q,       tag1_d;
   logic              v2_q,         v2_d;
   logic              tag2_q,       tag2_d;
   logic              rvalid0_q,    rvalid0_d;
   logic              rvalid1_q,    rvalid1_d;
   logic [DATA_W-1:0] rs_data_q,    rs_data_d;
   logic [DATA_W-1:0] rt_data_q,    rt_data_d;

`ifndef RF_ARB_FIXED_PRI_EN
   logic              ptr_q,        ptr_d;
`endif

   // win selects the requester (0/1); gnt is forced low while reset is asserted
   always_comb begin
      any_req = bus.req0_i | bus.req1_i;
`ifdef RF_ARB_FIXED_PRI_EN
      win     = ~bus.req0_i & bus.req1_i;
`else
      win     = (bus.req0_i & bus.req1_i) ? ptr_q : bus.req1_i;
`endif
      gnt0    = ~rst & any_req & ~win;
      gnt1    = ~rst & any_req &  win;
      granted = gnt0 | gnt1;
   end

   always_comb begin
      if (win) begin
         sel_we    = bus.we1_i;
         sel_rs    = bus.rs1_i;
         sel_rt    = bus.rt1_i;
         sel_rd    = bus.rd1_i;
         sel_wdata = bus.wdata1_i;
      end else begin
         sel_we    = bus.we0_i;
         sel_rs    = bus.rs0_i;
         sel_rt    = bus.rt0_i;
         sel_rd    = bus.rd0_i;
         sel_wdata = bus.wdata0_i;
      end
   end

   always_comb begin
      rf_rs_d      = rf_rs_q;
      rf_rt_d      = rf_rt_q;
      rf_rd_d      = rf_rd_q;
      rf_data_in_d = rf_data_in_q;
      rf_write_d   = 1'b0;
      v1_d         = 1'b0;
      tag1_d       = tag1_q;
`ifndef RF_ARB_FIXED_PRI_EN
      ptr_d        = ptr_q;
`endif
      if (granted) begin
         rf_rs_d      = sel_rs;
         rf_rt_d      = sel_rt;
         rf_rd_d      = sel_rd;
         rf_data_in_d = sel_wdata;
         rf_write_d   = sel_we;
         v1_d         = 1'b1;
         tag1_d       = win;
`ifndef RF_ARB_FIXED_PRI_EN
         ptr_d        = ~win;
`endif
      end

      // the memory samples stage-1 regs on the next edge; its outputs are captured one edge later
      v2_d      = v1_q;
      tag2_d    = tag1_q;
      rvalid0_d = v2_q & ~tag2_q;
      rvalid1_d = v2_q &  tag2_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      if (v2_q) begin
         rs_data_d = bus.rf_rs_out_i;
         rt_data_d = bus.rf_rt_out_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_rs_q      <= '0;
         rf_rt_q      <= '0;
         rf_rd_q      <= '0;
         rf_data_in_q <= '0;
         rf_write_q   <= 1'b0;
         v1_q         <= 1'b0;
         tag1_q       <= 1'b0;
         v2_q         <= 1'b0;
         tag2_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
`ifndef RF_ARB_FIXED_PRI_EN
         ptr_q        <= 1'b0;
`endif
      end else begin
         rf_rs_q      <= rf_rs_d;
         rf_rt_q      <= rf_rt_d;
         rf_rd_q      <= rf_rd_d;
         rf_data_in_q <= rf_data_in_d;
         rf_write_q   <= rf_write_d;
         v1_q         <= v1_d;
         tag1_q       <= tag1_d;
         v2_q         <= v2_d;
         tag2_q       <= tag2_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rs_data_q    <= rs_data_d;
         rt_data_q    <= rt_data_d;
`ifndef RF_ARB_FIXED_PRI_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign bus.gnt0_o       = gnt0;
   assign bus.gnt1_o       = gnt1;
   assign bus.rvalid0_o    = rvalid0_q;
   assign bus.rvalid1_o    = rvalid1_q;
   assign bus.rs_data_o    = rs_data_q;
   assign bus.rt_data_o    = rt_data_q;
   assign bus.rf_rs_o      = rf_rs_q;
   assign bus.rf_rt_o      = rf_rt_q;
   assign bus.rf_rd_o      = rf_rd_q;
   assign bus.rf_data_in_o = rf_data_in_q;
   assign bus.rf_write_o   = rf_write_q;

endmodule
